sdram_burst_responder: RTL and testbench
========================================

Name: sdram_burst_responder

Overview:
- Memory-side responder for the cache controller's line-fill and write-back bursts. It is the other end of the memstrb / wr_rd_sdram / addr_offset interface driven by cache_fsm.
- Models an SDRAM with row activate, CAS latency and precharge timing over an internal line-organised array.
- Accepts one line request, then exchanges 16 word strobes.
- Sits between cache_fsm/datapath and the top-level memory boundary; also serves as the cache bench's memory model.

Parameters:
- DATA_W, 32: word width.
- LINE_ADDR_W, 8: line address width (tag+index).
- DEPTH_LINES, 256: lines stored in the array, at most 2**LINE_ADDR_W.
- TRCD, 2: cycles spent in ACT, at least 1.
- CAS_LAT, 2: read strobe-to-data latency, at least 1.
- TRP, 2: cycles spent in PRE, at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- mem_req  in  1  line request, sampled only in IDLE.
- wr_rd_sdram  in  1  1 = write-back, 0 = fill; sampled with mem_req.
- line_addr  in  LINE_ADDR_W  line address; sampled with mem_req.
- memstrb  in  1  word strobe; accepted only while mem_rdy=1.
- addr_offset  in  4  word offset qualifying memstrb.
- wdata  in  DATA_W  write word, valid with memstrb.
- mem_rdy  out  1  high exactly while in BURST.
- rdata  out  DATA_W  read word.
- rvalid  out  1  one-cycle pulse qualifying rdata.
- roffset  out  4  offset tag for rdata.
- line_done  out  1  one-cycle pulse at end of transaction.
- busy  out  1  high whenever state is not IDLE.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; word counter, timer and read pipeline cleared.
- All outputs 0 during reset; rdata=0. Array contents are not cleared.
- States and transitions:
  - IDLE -> ACT on mem_req=1. Latch wr_rd_sdram and line_addr.
  - ACT holds exactly TRCD cycles, then -> BURST.
  - BURST: word counter wcnt counts 0..15. Each memstrb while mem_rdy=1 is one accepted word, and wcnt increments.
  - BURST: on the 16th accepted word -> DRAIN if read, -> PRE if write.
  - DRAIN holds CAS_LAT cycles, so the last rvalid occurs in the final DRAIN cycle; then -> PRE.
  - PRE holds TRP cycles, then -> DONE.
  - DONE lasts 1 cycle with line_done=1, then -> IDLE.
- Gaps between strobes in BURST are legal; there is no timeout.
- Write: an accepted strobe stores wdata at array[line][addr_offset] at that clock edge.
- Read: an accepted strobe produces rvalid=1 exactly CAS_LAT cycles later, with rdata=array[line][addr_offset] and roffset=addr_offset.
  - The read pipeline is CAS_LAT deep and supports back-to-back strobes.
- Addressing:
  - Array index is line_addr modulo DEPTH_LINES.
  - Word index is always addr_offset, even when it mismatches wcnt.
- Boundary conditions:
  - mem_req outside IDLE is ignored, with no effect on the current transaction.
  - memstrb while mem_rdy=0 is ignored: no write, no read, wcnt unchanged.
  - mem_req and a memstrb in the same IDLE cycle: the request is taken and the strobe ignored.
  - Reset mid-operation aborts the transaction and clears in-flight rvalid. A partially written line keeps the words already stored.
  - Read-after-write to the same line in consecutive transactions returns the new data; there is no bypass hazard because PRE and DONE separate them.

Optional Feature:
- Macro: SDRAM_PROTO_CHECK_EN.
- Defined: proto_err sets on any of:
  - memstrb while mem_rdy=0, except the IDLE cycle where mem_req is taken;
  - addr_offset != wcnt on an accepted strobe;
  - mem_req outside IDLE.
- Defined: proto_err clears only on reset.
- Undefined: proto_err tied to 0 and no check logic is generated. All other behaviour is identical.

Decomposition:
- Package sdram_resp_pkg holds:
  - state enum {IDLE, ACT, BURST, DRAIN, PRE, DONE};
  - WORDS_PER_LINE=16 and OFFSET_W=4;
  - default timing constants.
- Sub-module sdram_array holds the line array: one synchronous write port, and one read port feeding the CAS pipeline.
- FSM, counters, pipeline and checker stay in the top module.

Test Plan:
- Write-back: mem_req, wr_rd_sdram=1, line_addr=8'h05, then 16 strobes (offsets 0..15, wdata=32'hA000_0000+offset).
  - mem_rdy rises 2 cycles after ACT entry.
  - line_done occurs 3 cycles after the last strobe (PRE 2 + DONE).
  - busy drops the next cycle.
- Fill: read line 8'h05 with back-to-back strobes.
  - 16 rvalid pulses, each 2 cycles after its strobe.
  - rdata=32'hA000_0000+roffset.
  - line_done occurs 2+2+1 cycles after the last strobe.
- Gapped strobes: read with idle cycles between strobes.
  - rvalid spacing mirrors strobe spacing.
  - wcnt and state stay in BURST until the 16th strobe.
- Illegal stimulus:
  - A memstrb in ACT is ignored.
  - A mem_req in BURST is ignored.
  - Offset 3 sent when wcnt=2 stores at offset 3.
  - proto_err=1 with SDRAM_PROTO_CHECK_EN defined; proto_err=0 without it.
- Reset mid-burst: assert rst after 7 write words.
  - All outputs go to 0 immediately, and state returns to IDLE.
  - A subsequent fill of that line returns the new data at offsets 0..6 and the old data at offsets 7..15.
- Modulo addressing: with DEPTH_LINES=128, a write to line 8'h85 followed by a read of line 8'h05 returns identical data.

Source files
------------

// File: rtl/sdram_burst_responder_pkg.sv
// Shared types and constants for the SDRAM burst responder: FSM state encoding,
// line geometry and default ACT/CAS/PRE timing.
package sdram_resp_pkg;

  localparam int WORDS_PER_LINE = 16;
  localparam int OFFSET_W       = 4;
  localparam int TIMER_W        = 8;

  localparam int DEF_TRCD    = 2;
  localparam int DEF_CAS_LAT = 2;
  localparam int DEF_TRP     = 2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ACT   = 3'd1,
    BURST = 3'd2,
    DRAIN = 3'd3,
    PRE   = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/sdram_burst_responder_if.sv
// Cache-to-memory burst bus: one line request, then sixteen word strobes.
// Handshake: mem_req is taken only while busy=0; memstrb is a word transfer only
// in cycles where mem_rdy=1 (strobes elsewhere are dropped); rvalid qualifies
// rdata/roffset for exactly one cycle; line_done pulses once per transaction.
interface sdram_burst_responder_if #(
  parameter int DATA_W      = 32,
  parameter int LINE_ADDR_W = 8
);

  logic                               mem_req;
  logic                               wr_rd_sdram;
  logic [LINE_ADDR_W-1:0]             line_addr;
  logic                               memstrb;
  logic [sdram_resp_pkg::OFFSET_W-1:0] addr_offset;
  logic [DATA_W-1:0]                  wdata;

  logic                               mem_rdy;
  logic [DATA_W-1:0]                  rdata;
  logic                               rvalid;
  logic [sdram_resp_pkg::OFFSET_W-1:0] roffset;
  logic                               line_done;
  logic                               busy;
  logic                               proto_err;

  modport master (
    output mem_req, wr_rd_sdram, line_addr, memstrb, addr_offset, wdata,
    input  mem_rdy, rdata, rvalid, roffset, line_done, busy, proto_err
  );

  modport slave (
    input  mem_req, wr_rd_sdram, line_addr, memstrb, addr_offset, wdata,
    output mem_rdy, rdata, rvalid, roffset, line_done, busy, proto_err
  );

endinterface

// File: rtl/sdram_burst_responder_array.sv
// Line-organised storage: one synchronous write port and one combinational read
// port that feeds the CAS pipeline. Line address folds modulo DEPTH_LINES.
module sdram_array
  import sdram_resp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LINE_ADDR_W = 8,
  parameter int DEPTH_LINES = 256
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [LINE_ADDR_W-1:0] wr_line,
  input  logic [OFFSET_W-1:0]    wr_off,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic [LINE_ADDR_W-1:0] rd_line,
  input  logic [OFFSET_W-1:0]    rd_off,
  output logic [DATA_W-1:0]      rd_data
);

  localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;

  logic [DATA_W-1:0] mem [DEPTH_LINES][WORDS_PER_LINE];

  function automatic logic [IDX_W-1:0] line_index(input logic [LINE_ADDR_W-1:0] line);
    logic [31:0] wide;
    wide = 32'(line);
    return IDX_W'(wide % 32'(DEPTH_LINES));
  endfunction

  // Contents survive reset, so the array has no reset branch.
  always_ff @(posedge clk) begin
    if (we) mem[line_index(wr_line)][wr_off] <= wr_data;
  end

  assign rd_data = mem[line_index(rd_line)][rd_off];

endmodule

// File: rtl/sdram_burst_responder.sv
// SDRAM-style line responder: ACT (TRCD) -> BURST (16 strobes) -> DRAIN (CAS_LAT,
// reads only) -> PRE (TRP) -> DONE. Optional checker under SDRAM_PROTO_CHECK_EN.
module sdram_burst_responder
  import sdram_resp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int LINE_ADDR_W = 8,
  parameter int DEPTH_LINES = 256,
  parameter int TRCD        = DEF_TRCD,
  parameter int CAS_LAT     = DEF_CAS_LAT,
  parameter int TRP         = DEF_TRP
) (
  input  logic                clk,
  input  logic                rst,
  sdram_burst_responder_if.slave bus,
  output logic [2:0]          dbg_state,
  output logic [OFFSET_W-1:0] dbg_wcnt
);

  localparam logic [2:0] S_IDLE  = 3'(IDLE);
  localparam logic [2:0] S_ACT   = 3'(ACT);
  localparam logic [2:0] S_BURST = 3'(BURST);
  localparam logic [2:0] S_DRAIN = 3'(DRAIN);
  localparam logic [2:0] S_PRE   = 3'(PRE);
  localparam logic [2:0] S_DONE  = 3'(DONE);

  logic [2:0]             state;
  logic [TIMER_W-1:0]     timer;
  logic [OFFSET_W-1:0]    wcnt;
  logic                   wr_q;
  logic [LINE_ADDR_W-1:0] line_q;
  logic                   accept;
  logic                   last_word;
  logic                   timer_zero;
  logic                   rd_issue;
  logic [DATA_W-1:0]      arr_rdata;

  assign accept     = bus.memstrb && (state == S_BURST);
  assign last_word  = accept && (wcnt == OFFSET_W'(WORDS_PER_LINE - 1));
  assign timer_zero = (timer == '0);
  assign rd_issue   = accept && !wr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      timer  <= '0;
      wcnt   <= '0;
      wr_q   <= 1'b0;
      line_q <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.mem_req) begin
          state  <= S_ACT;
          timer  <= TIMER_W'(TRCD - 1);
          wcnt   <= '0;
          wr_q   <= bus.wr_rd_sdram;
          line_q <= bus.line_addr;
        end
        S_ACT: if (timer_zero) state <= S_BURST;
               else timer <= timer - TIMER_W'(1);
        S_BURST: if (accept) begin
          wcnt <= wcnt + OFFSET_W'(1);
          if (last_word) begin
            // Writes have nothing in flight, so they skip straight to precharge.
            state <= wr_q ? S_PRE : S_DRAIN;
            timer <= wr_q ? TIMER_W'(TRP - 1) : TIMER_W'(CAS_LAT - 1);
          end
        end
        S_DRAIN: if (timer_zero) begin
          state <= S_PRE;
          timer <= TIMER_W'(TRP - 1);
        end else begin
          timer <= timer - TIMER_W'(1);
        end
        S_PRE: if (timer_zero) state <= S_DONE;
               else timer <= timer - TIMER_W'(1);
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  sdram_array #(
    .DATA_W      (DATA_W),
    .LINE_ADDR_W (LINE_ADDR_W),
    .DEPTH_LINES (DEPTH_LINES)
  ) u_array (
    .clk     (clk),
    .we      (accept && wr_q),
    .wr_line (line_q),
    .wr_off  (bus.addr_offset),
    .wr_data (bus.wdata),
    .rd_line (line_q),
    .rd_off  (bus.addr_offset),
    .rd_data (arr_rdata)
  );

  logic [CAS_LAT-1:0]  pipe_v;
  logic [OFFSET_W-1:0] pipe_off [CAS_LAT];
  logic [DATA_W-1:0]   pipe_dat [CAS_LAT];

  // Data is captured at the strobe edge and shifted CAS_LAT stages; idle slots carry zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe_v <= '0;
      for (int i = 0; i < CAS_LAT; i++) begin
        pipe_off[i] <= '0;
        pipe_dat[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= rd_issue;
      pipe_off[0] <= rd_issue ? bus.addr_offset : '0;
      pipe_dat[0] <= rd_issue ? arr_rdata : '0;
      for (int i = 1; i < CAS_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_off[i] <= pipe_off[i-1];
        pipe_dat[i] <= pipe_dat[i-1];
      end
    end
  end

  assign bus.rvalid    = pipe_v[CAS_LAT-1];
  assign bus.rdata     = pipe_dat[CAS_LAT-1];
  assign bus.roffset   = pipe_off[CAS_LAT-1];
  assign bus.mem_rdy   = (state == S_BURST);
  assign bus.busy      = (state != S_IDLE);
  assign bus.line_done = (state == S_DONE);
  assign dbg_state     = state;
  assign dbg_wcnt      = wcnt;

`ifdef SDRAM_PROTO_CHECK_EN
  logic perr_q;
  logic perr_hit;

  // A strobe alongside the accepted request is tolerated; any other stray strobe is not.
  assign perr_hit = (bus.memstrb && (state != S_BURST) && !((state == S_IDLE) && bus.mem_req))
                 || (accept && (bus.addr_offset != wcnt))
                 || (bus.mem_req && (state != S_IDLE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          perr_q <= 1'b0;
    else if (perr_hit) perr_q <= 1'b1;
  end

  assign bus.proto_err = perr_q;
`else
  assign bus.proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_burst_responder.sv
// Directed bench for sdram_burst_responder: write-back, fill, gapped strobes,
// illegal stimulus, reset mid-burst and modulo line addressing (DEPTH_LINES=128).
module tb_sdram_burst_responder;
  import sdram_resp_pkg::*;

  localparam int DW    = 32;
  localparam int LW    = 8;
  localparam int DEPTH = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbg_state;
  logic [3:0] dbg_wcnt;

  sdram_burst_responder_if #(.DATA_W(DW), .LINE_ADDR_W(LW)) bus ();

  sdram_burst_responder #(
    .DATA_W(DW), .LINE_ADDR_W(LW), .DEPTH_LINES(DEPTH),
    .TRCD(2), .CAS_LAT(2), .TRP(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state),
    .dbg_wcnt  (dbg_wcnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- shared stimulus tables and observations ----------------
  int checks = 0;
  int errors = 0;

  logic [3:0]    off_tab [16];
  logic [DW-1:0] dat_tab [16];
  int            gap_tab [16];
  int            stb_cyc [16];
  logic [3:0]    wcnt_at [16];
  int  req_cyc, rdy_cyc, done_cyc, gap_bad;
  logic busy_done, busy_after;
  logic inj_idle_strobe = 1'b0, inj_act_strobe = 1'b0, inj_burst_req = 1'b0;

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q [$];
  logic [3:0]    got_off_q [$];
  logic [DW-1:0] got_dat_q [$];
  int            got_cyc_q [$];

  always @(negedge clk) begin
    if (bus.rvalid === 1'b1) begin
      got_off_q.push_back(bus.roffset);
      got_dat_q.push_back(bus.rdata);
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic clear_sb();
    exp_q.delete(); got_off_q.delete(); got_dat_q.delete(); got_cyc_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_tab(input logic [DW-1:0] base, input int gap_mod);
    for (int i = 0; i < 16; i++) begin
      off_tab[i] = 4'(i);
      dat_tab[i] = base + DW'(i);
      gap_tab[i] = (gap_mod > 0) ? (i % gap_mod) : 0;
    end
  endtask

  task automatic run_txn(input logic wr, input logic [LW-1:0] line, input int nwords);
    @(negedge clk);
    bus.mem_req = 1'b1; bus.wr_rd_sdram = wr; bus.line_addr = line;
    bus.memstrb = inj_idle_strobe; bus.addr_offset = 4'd9; bus.wdata = 32'h1111_1111;
    req_cyc = cyc;
    @(negedge clk);
    bus.mem_req = 1'b0;
    bus.memstrb = inj_act_strobe; bus.addr_offset = 4'd5; bus.wdata = 32'hDEAD_BEEF;
    rdy_cyc = -1;
    for (int i = 0; i < 20 && rdy_cyc < 0; i++) begin
      if (bus.mem_rdy === 1'b1) rdy_cyc = cyc;
      else begin @(negedge clk); bus.memstrb = 1'b0; end
    end
    bus.memstrb = 1'b0;
    gap_bad = 0;
    for (int w = 0; w < nwords; w++) begin
      for (int g = 0; g < gap_tab[w]; g++) begin
        if (dbg_state !== 3'(BURST) || dbg_wcnt !== 4'(w)) gap_bad++;
        @(negedge clk);
      end
      wcnt_at[w] = dbg_wcnt;
      stb_cyc[w] = cyc;
      bus.memstrb = 1'b1; bus.addr_offset = off_tab[w]; bus.wdata = dat_tab[w];
      if (w == 4 && inj_burst_req) begin
        bus.mem_req = 1'b1; bus.wr_rd_sdram = ~wr; bus.line_addr = 8'h33;
      end
      @(negedge clk);
      bus.memstrb = 1'b0; bus.mem_req = 1'b0; bus.wr_rd_sdram = wr; bus.line_addr = line;
    end
    done_cyc = -1; busy_done = 1'b0; busy_after = 1'b1;
    if (nwords == 16) begin
      for (int i = 0; i < 40 && done_cyc < 0; i++) begin
        if (bus.line_done === 1'b1) begin done_cyc = cyc; busy_done = bus.busy; end
        else @(negedge clk);
      end
      @(negedge clk);
      busy_after = bus.busy;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.mem_req = 1'b0; bus.wr_rd_sdram = 1'b0; bus.line_addr = '0;
    bus.memstrb = 1'b0; bus.addr_offset = '0; bus.wdata = '0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.mem_rdy, bus.rvalid, bus.line_done, bus.busy, bus.proto_err, bus.rdata, bus.roffset} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b rv=%b done=%b busy=%b perr=%b rdata=%h roff=%0d, want all 0",
               bus.mem_rdy, bus.rvalid, bus.line_done, bus.busy, bus.proto_err, bus.rdata, bus.roffset);
    end
    checks++;
    if (dbg_state !== 3'(IDLE) || dbg_wcnt !== 4'd0) begin
      errors++; $display("FAIL reset_state: state=%0d wcnt=%0d, want 0/0", dbg_state, dbg_wcnt);
    end
    rst = 1'b1;
  endtask

  task automatic test_write_back();
    set_tab(32'hA000_0000, 0);
    clear_sb();
    run_txn(1'b1, 8'h05, 16);
    checks++;
    if (rdy_cyc !== req_cyc + 3) begin
      errors++; $display("FAIL wb_rdy_latency: mem_rdy at cycle %0d, want %0d", rdy_cyc, req_cyc + 3);
    end
    checks++;
    if (done_cyc !== stb_cyc[15] + 3 || busy_done !== 1'b1) begin
      errors++; $display("FAIL wb_line_done: at cycle %0d busy=%b, want %0d busy=1", done_cyc, busy_done, stb_cyc[15] + 3);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++; $display("FAIL wb_busy_drop: busy=%b, want 0", busy_after);
    end
    checks++;
    if (got_dat_q.size() !== 0) begin
      errors++; $display("FAIL wb_no_rvalid: got %0d rvalid pulses, want 0", got_dat_q.size());
    end
  endtask

  task automatic test_fill();
    set_tab(32'h0, 0);
    clear_sb();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA000_0000 + DW'(i));
    run_txn(1'b0, 8'h05, 16);
    checks++;
    if (got_dat_q.size() !== 16) begin
      errors++; $display("FAIL fill_count: got %0d rvalid, want 16", got_dat_q.size());
    end
    for (int i = 0; i < 16 && i < got_dat_q.size(); i++) begin
      checks++;
      if (got_off_q[i] !== off_tab[i] || got_dat_q[i] !== exp_q[i] || got_cyc_q[i] !== stb_cyc[i] + 2) begin
        errors++;
        $display("FAIL fill_word%0d: off=%0d data=%h cyc=%0d, want off=%0d data=%h cyc=%0d",
                 i, got_off_q[i], got_dat_q[i], got_cyc_q[i], off_tab[i], exp_q[i], stb_cyc[i] + 2);
      end
    end
    checks++;
    if (done_cyc !== stb_cyc[15] + 5 || busy_after !== 1'b0) begin
      errors++; $display("FAIL fill_line_done: at cycle %0d busy_after=%b, want %0d busy_after=0",
                         done_cyc, busy_after, stb_cyc[15] + 5);
    end
  endtask

  task automatic test_gapped();
    set_tab(32'h0, 3);
    clear_sb();
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hA000_0000 + DW'(i));
    run_txn(1'b0, 8'h05, 16);
    checks++;
    if (gap_bad !== 0) begin
      errors++; $display("FAIL gap_hold: %0d gap cycles left BURST or moved wcnt, want 0", gap_bad);
    end
    checks++;
    if (got_dat_q.size() !== 16) begin
      errors++; $display("FAIL gap_count: got %0d rvalid, want 16", got_dat_q.size());
    end
    for (int i = 0; i < 16 && i < got_dat_q.size(); i++) begin
      checks++;
      if (got_off_q[i] !== off_tab[i] || got_dat_q[i] !== exp_q[i] || got_cyc_q[i] !== stb_cyc[i] + 2) begin
        errors++;
        $display("FAIL gap_word%0d: off=%0d data=%h cyc=%0d, want off=%0d data=%h cyc=%0d",
                 i, got_off_q[i], got_dat_q[i], got_cyc_q[i], off_tab[i], exp_q[i], stb_cyc[i] + 2);
      end
    end
    checks++;
    if (bus.proto_err !== 1'b0) begin
      errors++; $display("FAIL legal_no_perr: proto_err=%b, want 0", bus.proto_err);
    end
  endtask

  task automatic test_illegal();
    logic exp_perr;
`ifdef SDRAM_PROTO_CHECK_EN
    exp_perr = 1'b1;
`else
    exp_perr = 1'b0;
`endif
    set_tab(32'h0, 0);
    off_tab[2] = 4'd3; off_tab[3] = 4'd2;
    for (int i = 0; i < 16; i++) dat_tab[i] = 32'hB000_0000 + DW'(off_tab[i]);
    clear_sb();
    inj_act_strobe = 1'b1; inj_burst_req = 1'b1;
    run_txn(1'b1, 8'h10, 16);
    inj_act_strobe = 1'b0; inj_burst_req = 1'b0;
    checks++;
    if (wcnt_at[0] !== 4'd0 || wcnt_at[2] !== 4'd2 || wcnt_at[5] !== 4'd5) begin
      errors++; $display("FAIL act_strobe_ignored: wcnt %0d/%0d/%0d at words 0/2/5, want 0/2/5",
                         wcnt_at[0], wcnt_at[2], wcnt_at[5]);
    end
    checks++;
    if (done_cyc !== stb_cyc[15] + 3) begin
      errors++; $display("FAIL burst_req_ignored: line_done at %0d, want %0d (write path)", done_cyc, stb_cyc[15] + 3);
    end
    checks++;
    if (bus.proto_err !== exp_perr) begin
      errors++; $display("FAIL proto_err_flag: proto_err=%b, want %b", bus.proto_err, exp_perr);
    end
    set_tab(32'h0, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hB000_0000 + DW'(i));
    inj_idle_strobe = 1'b1;
    run_txn(1'b0, 8'h10, 16);
    inj_idle_strobe = 1'b0;
    checks++;
    if (got_dat_q.size() !== 16) begin
      errors++; $display("FAIL idle_strobe_ignored: got %0d rvalid, want 16", got_dat_q.size());
    end
    for (int i = 0; i < 16 && i < got_dat_q.size(); i++) begin
      checks++;
      if (got_off_q[i] !== off_tab[i] || got_dat_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL offset_index%0d: off=%0d data=%h, want off=%0d data=%h",
                           i, got_off_q[i], got_dat_q[i], off_tab[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    set_tab(32'hC000_0000, 0);
    clear_sb();
    run_txn(1'b1, 8'h05, 7);
    checks++;
    if (bus.mem_rdy !== 1'b1 || dbg_state !== 3'(BURST)) begin
      errors++; $display("FAIL pre_reset_burst: mem_rdy=%b state=%0d, want 1/BURST", bus.mem_rdy, dbg_state);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.mem_rdy, bus.rvalid, bus.line_done, bus.busy, bus.proto_err, bus.rdata, bus.roffset} !== '0
        || dbg_state !== 3'(IDLE)) begin
      errors++; $display("FAIL mid_reset_outputs: rdy=%b busy=%b perr=%b state=%0d, want 0/0/0/IDLE",
                         bus.mem_rdy, bus.busy, bus.proto_err, dbg_state);
    end
    @(negedge clk);
    rst = 1'b1;
    set_tab(32'h0, 0);
    for (int i = 0; i < 16; i++) exp_q.push_back((i < 7) ? 32'hC000_0000 + DW'(i) : 32'hA000_0000 + DW'(i));
    run_txn(1'b0, 8'h05, 16);
    checks++;
    if (got_dat_q.size() !== 16) begin
      errors++; $display("FAIL partial_count: got %0d rvalid, want 16", got_dat_q.size());
    end
    for (int i = 0; i < 16 && i < got_dat_q.size(); i++) begin
      checks++;
      if (got_off_q[i] !== off_tab[i] || got_dat_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL partial_word%0d: off=%0d data=%h, want off=%0d data=%h",
                           i, got_off_q[i], got_dat_q[i], off_tab[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_modulo();
    set_tab(32'hD000_0000, 0);
    clear_sb();
    run_txn(1'b1, 8'h85, 16);
    for (int i = 0; i < 16; i++) exp_q.push_back(32'hD000_0000 + DW'(i));
    run_txn(1'b0, 8'h05, 16);
    checks++;
    if (got_dat_q.size() !== 16) begin
      errors++; $display("FAIL modulo_count: got %0d rvalid, want 16", got_dat_q.size());
    end
    for (int i = 0; i < 16 && i < got_dat_q.size(); i++) begin
      checks++;
      if (got_off_q[i] !== off_tab[i] || got_dat_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL modulo_word%0d: off=%0d data=%h, want off=%0d data=%h",
                           i, got_off_q[i], got_dat_q[i], off_tab[i], exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_back();
    test_fill();
    test_gapped();
    test_illegal();
    test_reset_mid_burst();
    test_modulo();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
